// File: rtl/gate_ref_model.sv
// gate_ref_model: registered golden-reference model of six 2-input gates.
// Each gate has its own combinational submodule. An 8-way select mux follows,
// then a single output register stage, so the latency is one clock.
// Optional macro GATE_REF_COMPARE_EN adds the dut_y input and the
// mismatch / mismatch_cnt outputs.

module gate_ref_and2 (
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic [3:0] tt
);
  // Gate output, plus the truth table indexed by {b,a}
  always_comb begin
    y = a & b;
    for (int unsigned i = 0; i < 4; i++) tt[i] = i[0] & i[1];
  end
endmodule

module gate_ref_or2 (
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic [3:0] tt
);
  // Gate output, plus the truth table indexed by {b,a}
  always_comb begin
    y = a | b;
    for (int unsigned i = 0; i < 4; i++) tt[i] = i[0] | i[1];
  end
endmodule

module gate_ref_nand2 (
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic [3:0] tt
);
  // Gate output, plus the truth table indexed by {b,a}
  always_comb begin
    y = ~(a & b);
    for (int unsigned i = 0; i < 4; i++) tt[i] = ~(i[0] & i[1]);
  end
endmodule

module gate_ref_nor2 (
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic [3:0] tt
);
  // Gate output, plus the truth table indexed by {b,a}
  always_comb begin
    y = ~(a | b);
    for (int unsigned i = 0; i < 4; i++) tt[i] = ~(i[0] | i[1]);
  end
endmodule

module gate_ref_xor2 (
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic [3:0] tt
);
  // Gate output, plus the truth table indexed by {b,a}
  always_comb begin
    y = a ^ b;
    for (int unsigned i = 0; i < 4; i++) tt[i] = i[0] ^ i[1];
  end
endmodule

module gate_ref_xnor2 (
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic [3:0] tt
);
  // Gate output, plus the truth table indexed by {b,a}
  always_comb begin
    y = ~(a ^ b);
    for (int unsigned i = 0; i < 4; i++) tt[i] = ~(i[0] ^ i[1]);
  end
endmodule

module gate_ref_model #(
  parameter logic INVALID_Y    = 1'b0,
  parameter int   HOLD_ON_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic [2:0] sel,
  output logic       out_valid,
  output logic       y,
  output logic [3:0] truth_table,
  output logic       sel_err
`ifdef GATE_REF_COMPARE_EN
  ,
  input  logic       dut_y,
  output logic       mismatch,
  output logic [7:0] mismatch_cnt
`endif
);

  logic [5:0] y_fn;
  logic [3:0] tt_fn [6];

  gate_ref_and2  u_and  (.a(a), .b(b), .y(y_fn[0]), .tt(tt_fn[0]));
  gate_ref_or2   u_or   (.a(a), .b(b), .y(y_fn[1]), .tt(tt_fn[1]));
  gate_ref_nand2 u_nand (.a(a), .b(b), .y(y_fn[2]), .tt(tt_fn[2]));
  gate_ref_nor2  u_nor  (.a(a), .b(b), .y(y_fn[3]), .tt(tt_fn[3]));
  gate_ref_xor2  u_xor  (.a(a), .b(b), .y(y_fn[4]), .tt(tt_fn[4]));
  gate_ref_xnor2 u_xnor (.a(a), .b(b), .y(y_fn[5]), .tt(tt_fn[5]));

  logic       y_sel;
  logic [3:0] tt_sel;
  logic       sel_bad;

  // 8-way select mux; the two unused codes drive INVALID_Y
  always_comb begin
    y_sel   = INVALID_Y;
    tt_sel  = {4{INVALID_Y}};
    sel_bad = 1'b0;
    case (sel)
      3'b000: begin y_sel = y_fn[0]; tt_sel = tt_fn[0]; end
      3'b001: begin y_sel = y_fn[1]; tt_sel = tt_fn[1]; end
      3'b010: begin y_sel = y_fn[2]; tt_sel = tt_fn[2]; end
      3'b011: begin y_sel = y_fn[3]; tt_sel = tt_fn[3]; end
      3'b100: begin y_sel = y_fn[4]; tt_sel = tt_fn[4]; end
      3'b101: begin y_sel = y_fn[5]; tt_sel = tt_fn[5]; end
      default: sel_bad = 1'b1;
    endcase
  end

  logic       out_valid_d, out_valid_q;
  logic       y_d, y_q;
  logic [3:0] tt_d, tt_q;
  logic       sel_err_d, sel_err_q;

  // Next-state: capture on valid; on idle either hold or clear y and the table
  always_comb begin
    out_valid_d = in_valid;
    sel_err_d   = in_valid & sel_bad;
    y_d         = y_q;
    tt_d        = tt_q;
    if (in_valid) begin
      y_d  = y_sel;
      tt_d = tt_sel;
    end else if (HOLD_ON_IDLE == 0) begin
      y_d  = 1'b0;
      tt_d = '0;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= 1'b0;
      tt_q        <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      tt_q        <= tt_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign y           = y_q;
  assign truth_table = tt_q;
  assign sel_err     = sel_err_q;

`ifdef GATE_REF_COMPARE_EN
  logic       mismatch_d, mismatch_q;
  logic [7:0] cnt_d, cnt_q;

  // Pin-reading comparison; the counter saturates at 255
  always_comb begin
    mismatch_d = in_valid & ~sel_bad & (dut_y != y_sel);
    cnt_d      = cnt_q;
    if (mismatch_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  // Comparison result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign mismatch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gate_ref_model.sv
// Directed-vector bench for gate_ref_model: a default instance (hold on idle,
// INVALID_Y=0) and a second instance (clear on idle, INVALID_Y=1).
module tb_gate_ref_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, a, b;
  logic [2:0] sel;
  logic       dut_y;

  logic       ov0, y0, se0;
  logic [3:0] tt0;
  logic       ov1, y1, se1;
  logic [3:0] tt1;
`ifdef GATE_REF_COMPARE_EN
  logic       mm0, mm1;
  logic [7:0] mc0, mc1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gate_ref_model #(.INVALID_Y(1'b0), .HOLD_ON_IDLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
    .out_valid(ov0), .y(y0), .truth_table(tt0), .sel_err(se0)
`ifdef GATE_REF_COMPARE_EN
    , .dut_y(dut_y), .mismatch(mm0), .mismatch_cnt(mc0)
`endif
  );

  gate_ref_model #(.INVALID_Y(1'b1), .HOLD_ON_IDLE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .sel(sel),
    .out_valid(ov1), .y(y1), .truth_table(tt1), .sel_err(se1)
`ifdef GATE_REF_COMPARE_EN
    , .dut_y(dut_y), .mismatch(mm1), .mismatch_cnt(mc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one sample, clock it in, then sample outputs 1 time unit after the edge
  task automatic apply(input logic v, input logic ai, input logic bi,
                       input logic [2:0] s, input logic dy);
    in_valid = v; a = ai; b = bi; sel = s; dut_y = dy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic ov, input logic yy,
                      input logic [3:0] tt, input logic se);
    chk({tag, ".out_valid"}, 32'(ov0), 32'(ov));
    chk({tag, ".y"},         32'(y0),  32'(yy));
    chk({tag, ".tt"},        32'(tt0), 32'(tt));
    chk({tag, ".sel_err"},   32'(se0), 32'(se));
  endtask

  // Vector tables: {a,b} per step and expected y
  logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       and_y  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       nand_y [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [2:0] walk_sel [4] = '{3'b001, 3'b011, 3'b100, 3'b101};
  logic       walk_y   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] walk_tt  [4] = '{4'b1110, 4'b0001, 4'b0110, 4'b1001};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; sel = 3'b000; dut_y = 1'b0;
    #1;
    chk0("por", 1'b0, 1'b0, 4'b0000, 1'b0);
    #10 rst_n = 1'b1;

    // Asynchronous reset mid-cycle with a valid sample presented
    apply(1'b1, 1'b1, 1'b1, 3'b001, 1'b1);
    chk0("pre_rst", 1'b1, 1'b1, 4'b1110, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk0("async_rst", 1'b0, 1'b0, 4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    chk0("post_rst_idle", 1'b0, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < 4; i++) begin
      apply(1'b1, pat[i][1], pat[i][0], 3'b000, 1'b0);
      chk0($sformatf("and%0d", i), 1'b1, and_y[i], 4'b1000, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, pat[i][1], pat[i][0], 3'b010, 1'b0);
      chk0($sformatf("nand%0d", i), 1'b1, nand_y[i], 4'b0111, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 1'b0, walk_sel[i], 1'b0);
      chk0($sformatf("walk%0d", i), 1'b1, walk_y[i], walk_tt[i], 1'b0);
    end

    // Idle after y=1: instance 0 holds, instance 1 clears
    apply(1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    chk0("idle_hold", 1'b0, 1'b1, 4'b1110, 1'b0);
    chk("idle_clr.y",  32'(y1),  32'(1'b0));
    chk("idle_clr.tt", 32'(tt1), 32'(4'b0000));
    chk("idle_clr.ov", 32'(ov1), 32'(1'b0));

    // Invalid select codes
    apply(1'b1, 1'b1, 1'b0, 3'b111, 1'b0);
    chk0("inv111", 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("inv111_i1.y",  32'(y1),  32'(1'b1));
    chk("inv111_i1.tt", 32'(tt1), 32'(4'b1111));
    chk("inv111_i1.se", 32'(se1), 32'(1'b1));
    apply(1'b0, 1'b1, 1'b1, 3'b111, 1'b0);
    chk0("inv_idle", 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("inv_idle_i1.y", 32'(y1), 32'(1'b0));
    apply(1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
    chk0("inv110", 1'b1, 1'b0, 4'b0000, 1'b1);
    chk("inv110_i1.tt", 32'(tt1), 32'(4'b1111));

    // Back-to-back valid with sel change taking effect only on the next sample
    apply(1'b1, 1'b0, 1'b1, 3'b100, 1'b0);
    chk0("b2b_xor", 1'b1, 1'b1, 4'b0110, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
    chk0("b2b_xnor", 1'b1, 1'b0, 4'b1001, 1'b0);

`ifdef GATE_REF_COMPARE_EN
    rst_n = 1'b0;
    #1;
    chk("cmp_rst.cnt", 32'(mc0), 32'd0);
    rst_n = 1'b1;
    apply(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
    chk("cmp.mm",  32'(mm0), 32'(1'b1));
    chk("cmp.cnt", 32'(mc0), 32'd1);
    apply(1'b1, 1'b1, 1'b1, 3'b000, 1'b1);
    chk("cmp_match.mm",  32'(mm0), 32'(1'b0));
    chk("cmp_match.cnt", 32'(mc0), 32'd1);
    apply(1'b1, 1'b1, 1'b1, 3'b111, 1'b1);
    chk("cmp_inv.mm", 32'(mm0), 32'(1'b0));
    for (int i = 0; i < 300; i++) apply(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
    chk("cmp_sat.cnt", 32'(mc0), 32'd255);
    apply(1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
    chk("cmp_idle.mm",  32'(mm0), 32'(1'b0));
    chk("cmp_idle.cnt", 32'(mc0), 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
